// File: rtl/ascon_pack.sv
// Shared definitions for the ASCON cipher/tag output buffer: default widths
// and the output-sequencer state type.
package ascon_pack;

  localparam int ASCON_DATA_W = 64;
  localparam int ASCON_TAG_W  = 128;

  typedef enum logic {
    S_CT  = 1'b0,
    S_TAG = 1'b1
  } type_ct_state;

endpackage

// File: rtl/ascon_sync_fifo.sv
// Single-clock FIFO for ciphertext blocks: power-of-two depth, naturally
// wrapping pointers and an explicit occupancy count (0..DEPTH).
// With ASCON_CT_ZEROIZE_EN defined, each entry is cleared as it is popped.
module ascon_sync_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok;
  logic              pop_ok;

  // Guard locally so the storage can never be overrun or under-read.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH by width.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: written on push, optionally scrubbed on pop.
  // NOTE: the array is deliberately not reset; validity is defined by the
  // pointers and count, so stale contents are never presented as valid.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
`ifdef ASCON_CT_ZEROIZE_EN
    if (pop_ok) mem_q[rd_ptr_q] <= '0;
`endif
  end

endmodule

// File: rtl/ascon_ct_tag_buffer.sv
// ASCON output buffer: queues ciphertext blocks in a FIFO, captures the
// authentication tag, and serialises both onto one valid/ready stream
// (cipher blocks first, then the tag MSB-first as TAG_W/DATA_W beats).
// Optional macro ASCON_CT_ZEROIZE_EN scrubs popped FIFO entries and the tag
// register after use. The idle output beat reads as zero in every build.
module ascon_ct_tag_buffer
  import ascon_pack::*;
#(
  parameter int DATA_W = ASCON_DATA_W,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = ASCON_TAG_W
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     ct_valid_i,
  input  logic [DATA_W-1:0]        ct_data_i,
  output logic                     ct_ready_o,
  input  logic                     tag_valid_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     tag_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_is_tag_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o
);

  localparam int BEATS  = TAG_W / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  type_ct_state       state_q, state_d;
  logic               tag_pending_q, tag_pending_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic [DATA_W-1:0]  fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               ct_accept;
  logic               tag_accept;
  logic               last_beat;
  logic [DATA_W-1:0]  tag_beat;

  // Readiness depends only on registered state, never on out_ready_i.
  assign ct_ready_o  = !fifo_full && !tag_pending_q;
  assign tag_ready_o = !tag_pending_q;
  assign ct_accept   = ct_valid_i && ct_ready_o;
  assign tag_accept  = tag_valid_i && tag_ready_o;
  assign fifo_push   = ct_accept;
  assign count_o     = fifo_count;
  assign busy_o      = !fifo_empty || tag_pending_q;

  ascon_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (fifo_push),
    .push_data_i (ct_data_i),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Select the current tag beat, most significant slice first.
  always_comb begin
    tag_beat = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_q == BEAT_W'(i)) tag_beat = tag_q[TAG_W-1-i*DATA_W -: DATA_W];
    end
  end

  // Next-state, tag capture and output-beat logic for the sequencer.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    tag_pending_d = tag_pending_q;
    tag_d         = tag_q;
    beat_d        = beat_q;
    out_valid_o   = 1'b0;
    out_data_o    = '0;
    out_is_tag_o  = 1'b0;
    out_last_o    = 1'b0;
    fifo_pop      = 1'b0;
    last_beat     = (beat_q == BEAT_W'(BEATS - 1));

    if (tag_accept) begin
      tag_d         = tag_i;
      tag_pending_d = 1'b1;
    end

    case (state_q)
      S_CT: begin
        out_valid_o = !fifo_empty;
        out_data_o  = fifo_empty ? '0 : fifo_head;
        fifo_pop    = out_valid_o && out_ready_i;
        // Move to the tag once the last queued block has left (or none remain).
        if (tag_pending_q && (fifo_empty || (fifo_pop && fifo_count == CNT_W'(1)))) begin
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        out_valid_o  = 1'b1;
        out_is_tag_o = 1'b1;
        out_data_o   = tag_beat;
        out_last_o   = last_beat;
        if (out_ready_i) begin
          if (last_beat) begin
            beat_d        = '0;
            tag_pending_d = 1'b0;
            state_d       = S_CT;
`ifdef ASCON_CT_ZEROIZE_EN
            tag_d         = '0;
`endif
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = S_CT;
    endcase
  end

  // Sequencer, tag register and beat counter state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_CT;
      tag_pending_q <= 1'b0;
      tag_q         <= '0;
      beat_q        <= '0;
    end else begin
      state_q       <= state_d;
      tag_pending_q <= tag_pending_d;
      tag_q         <= tag_d;
      beat_q        <= beat_d;
    end
  end

endmodule

// File: tb/tb_ascon_ct_tag_buffer.sv
// Self-checking bench for ascon_ct_tag_buffer: a driver issues directed and
// random stimulus; a negedge monitor keeps a message-level reference model
// (queue of expected beats, occupancy, tag-pending flag) and checks the DUT.
module tb_ascon_ct_tag_buffer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 128;
  localparam int BEATS  = TAG_W / DATA_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ct_valid = 1'b0;
  logic [DATA_W-1:0] ct_data = '0;
  logic              ct_ready;
  logic              tag_valid = 1'b0;
  logic [TAG_W-1:0]  tag_val = '0;
  logic              tag_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_is_tag;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              busy;

  always #5 clock = ~clock;

  ascon_ct_tag_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .ct_valid_i   (ct_valid),
    .ct_data_i    (ct_data),
    .ct_ready_o   (ct_ready),
    .tag_valid_i  (tag_valid),
    .tag_i        (tag_val),
    .tag_ready_o  (tag_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_is_tag_o (out_is_tag),
    .out_last_o   (out_last),
    .out_ready_i  (out_ready),
    .count_o      (count),
    .busy_o       (busy)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                is_tag;
    bit                last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    model_occ = 0;
  bit    model_tag_pend = 1'b0;
  bit    mon_en = 1'b0;
  bit    done = 1'b0;
  bit    post_reset = 1'b0;
  bit    hold_prev = 1'b0;
  beat_t prev_beat;
  int    stall = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: checks state against the model, then applies the
  // handshakes that will take effect at the coming rising edge.
  always @(negedge clock) begin
    if (mon_en && !done) begin
      check("count_o", count, model_occ);
      check("ct_ready_o", ct_ready, (model_occ < DEPTH) && !model_tag_pend);
      check("tag_ready_o", tag_ready, !model_tag_pend);
      check("busy_o", busy, (model_occ != 0) || model_tag_pend);
      if (exp_q.size() == 0) check("out_valid_idle", out_valid, 1'b0);
      if (post_reset) begin
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);
        check("reset_out_is_tag", out_is_tag, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        post_reset = 1'b0;
      end
      if (hold_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_beat.data);
        check("hold_is_tag", out_is_tag, prev_beat.is_tag);
        check("hold_last", out_last, prev_beat.last);
      end
`ifdef ASCON_CT_ZEROIZE_EN
      if (!out_valid) check("idle_data_zero", out_data, '0);
`endif
      if (exp_q.size() != 0 && !out_valid) begin
        stall++;
        if (stall > 3) begin
          check("out_valid_progress", out_valid, 1'b1);
          stall = 0;
        end
      end else begin
        stall = 0;
      end

      if (reset) begin
        exp_q.delete();
        model_occ      = 0;
        model_tag_pend = 1'b0;
        post_reset     = 1'b1;
        hold_prev      = 1'b0;
        stall          = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", out_valid, 1'b0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_is_tag", out_is_tag, e.is_tag);
            check("out_last", out_last, e.last);
            if (!e.is_tag) model_occ--;
            if (e.last) model_tag_pend = 1'b0;
          end
        end
        if (ct_valid && ct_ready) begin
          exp_q.push_back('{data: ct_data, is_tag: 1'b0, last: 1'b0});
          model_occ++;
        end
        if (tag_valid && tag_ready) begin
          logic [TAG_W-1:0] t;
          t = tag_val;
          for (int k = 0; k < BEATS; k++) begin
            exp_q.push_back('{data: t[TAG_W-1 -: DATA_W], is_tag: 1'b1, last: (k == BEATS - 1)});
            t = t << DATA_W;
          end
          model_tag_pend = 1'b1;
        end
        hold_prev = out_valid && !out_ready;
        prev_beat = '{data: out_data, is_tag: out_is_tag, last: out_last};
      end
    end
  end

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(input bit ctv, input logic [DATA_W-1:0] ctd, input bit tv,
                       input logic [TAG_W-1:0] tg, input bit ordy, input bit rst = 1'b0);
    @(posedge clock);
    #1;
    ct_valid  = ctv;
    ct_data   = ctd;
    tag_valid = tv;
    tag_val   = tg;
    out_ready = ordy;
    reset     = rst;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, ordy);
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clock);
    #1;
    reset      = 1'b0;
    post_reset = 1'b1;
    mon_en     = 1'b1;

    // Basic message: three blocks then a two-beat tag.
    drive(1'b1, 64'h1111, 1'b0, '0, 1'b1);
    drive(1'b1, 64'h2222, 1'b0, '0, 1'b1);
    drive(1'b1, 64'h3333, 1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234, 1'b1);
    idle(6, 1'b1);

    // Fill to DEPTH with the consumer stalled; the fifth push is refused.
    for (int i = 0; i < 5; i++) drive(1'b1, 64'h100 + 64'(i), 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    idle(8, 1'b1);

    // Tag with two blocks queued; a second tag and further blocks are refused.
    drive(1'b1, 64'h2001, 1'b0, '0, 1'b0);
    drive(1'b1, 64'h2002, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    drive(1'b0, '0, 1'b1, 128'h5555_5555_5555_5555_6666_6666_6666_6666, 1'b0);
    drive(1'b1, 64'h2003, 1'b1, 128'h7777_7777_7777_7777_8888_8888_8888_8888, 1'b0);
    drive(1'b1, 64'h2004, 1'b0, '0, 1'b1);
    idle(8, 1'b1);

    // Steady push+pop at occupancy 2 across pointer wrap.
    drive(1'b1, 64'h3000, 1'b0, '0, 1'b0);
    drive(1'b1, 64'h3001, 1'b0, '0, 1'b0);
    for (int i = 2; i < 12; i++) drive(1'b1, 64'h3000 + 64'(i), 1'b0, '0, 1'b1);
    idle(6, 1'b1);

    // Cipher block and tag accepted together, then reset after the first tag beat.
    drive(1'b1, 64'h4444, 1'b1, 128'h9999_8888_7777_6666_5555_4444_3333_2222, 1'b0);
    idle(2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clock);
      if (out_valid && out_is_tag && !out_last) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL mid_tag_wait: first tag beat not seen within 20 cycles");
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6, {$urandom, $urandom},
            $urandom_range(0, 19) == 0, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 7, $urandom_range(0, 499) == 0);
    end
    idle(12, 1'b1);

`ifdef ASCON_CT_ZEROIZE_EN
    // Scrubbing: a drained entry and the idle output read as zero.
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 64'hDEAD, 1'b0, '0, 1'b1);
    idle(5, 1'b1);
    @(negedge clock);
    check("zeroize_mem_entry", dut.u_fifo.mem_q[0], '0);
    check("zeroize_idle_data", out_data, '0);
`endif

    @(negedge clock);
    check("final_queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
